regfile_wb_sched: RTL

- Write-back scheduler for the 32x32 MIPS register file's single write port.
- After reset, sequences an init sweep that writes each register with its own index (r[i] = i, r0 = 0).
- Afterwards, shares the write port round-robin among NUM_REQ write-back requesters (ALU, load, mult/div) using a valid/ready handshake.
- Sits between the pipeline's write-back sources and the register file's RegWrite / write_reg / write_data inputs.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_wb_sched_if.sv | 18 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/regfile_wb_sched.sv | 130 +++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file geometry and scheduler state encoding.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Write-back request bundle: per-requester valid/ready with packed address and data.
interface regfile_wb_sched_if
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = REG_DATA_W,
  parameter int unsigned ADDR_W  = REG_ADDR_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, modulo N.
module rr_arbiter #(
  parameter int unsigned N = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % int'(N);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler: init sweep r[i]=i, then round-robin write-back.
// Optional decode bypass compare enabled by WB_SCHED_BYPASS_EN.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = REG_DATA_W,
  parameter int unsigned ADDR_W  = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_sched_if.slave wb,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
`ifdef WB_SCHED_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] byp_addr_a,
  input  logic [ADDR_W-1:0] byp_addr_b,
  output logic              byp_hit_a,
  output logic              byp_hit_b,
  output logic [DATA_W-1:0] byp_data
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                init_done_q, init_done_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                hs;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (wb.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign wb.req_ready = (state_q == RUN) ? gnt : '0;
  assign hs           = (state_q == RUN) && (|gnt);

  // Select the granted requester's packed address/data slice.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_addr = wb.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = wb.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    init_done_d = init_done_q;
    case (state_q)
      INIT: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = init_cnt_q;
        rf_wdata_d = DATA_W'(init_cnt_q);
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        // Writes to r0 complete the handshake but never assert the enable.
        if (hs) begin
          rf_waddr_d = sel_addr;
          rf_wdata_d = sel_data;
          rf_we_d    = (sel_addr != '0);
          rr_ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_done = init_done_q;

`ifdef WB_SCHED_BYPASS_EN
  // Decode forwards the value currently on the write port.
  assign byp_hit_a = rf_we_q && (rf_waddr_q == byp_addr_a) && (byp_addr_a != '0);
  assign byp_hit_b = rf_we_q && (rf_waddr_q == byp_addr_b) && (byp_addr_b != '0);
  assign byp_data  = rf_wdata_q;
`endif

endmodule
